// File: rtl/johnson_pkg.sv
// Johnson ring helpers shared by the phase monitor and its decoder.
// Codes are handled as 32-bit vectors so any width up to 32 can use them.
package johnson_pkg;

  localparam int JN    = 4;
  localparam int JRING = 2 * JN;
  localparam int JIW   = $clog2(JRING);

  function automatic logic [31:0] johnson_mask(input int n);
    logic [31:0] r;
    if (n >= 32) r = '1;
    else         r = (32'd1 << n) - 32'd1;
    return r;
  endfunction

  // next(c) = {c[n-2:0], ~c[n-1]}
  function automatic logic [31:0] johnson_next(input int n,
                                               input logic [31:0] c);
    logic [31:0] s;
    logic [31:0] r;
    s    = c >> (n - 1);
    r    = (c << 1) & johnson_mask(n);
    r[0] = ~s[0];
    return r;
  endfunction

  // Phase k: low k bits set for k<=n, else bits [n-1:k-n] set.
  function automatic logic [31:0] johnson_code(input int n,
                                               input int k);
    logic [31:0] r;
    if (k <= n) r = (32'd1 << k) - 32'd1;
    else        r = johnson_mask(n) & ~((32'd1 << (k - n)) - 32'd1);
    return r;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: legal flag, phase index, one-hot.
// Ports: i_code in; o_legal, o_idx, o_onehot out (zeros when illegal).
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int N  = JN,
  parameter int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]   i_code,
  output logic           o_legal,
  output logic [IW-1:0]  o_idx,
  output logic [2*N-1:0] o_onehot
);

  always_comb begin
    o_legal  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    for (int k = 0; k < 2 * N; k++) begin
      if (32'(i_code) == johnson_code(N, k)) begin
        o_legal     = 1'b1;
        o_idx       = IW'(k);
        o_onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Registers and checks a Johnson counter code: phase decode, sequencing,
// cycle and error counting. Outputs lag count_in by one clock.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int N  = JN,
  parameter int IW = $clog2(2 * N),
  parameter int CW = 8,
  parameter int EW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   count_in,
  input  logic           clear_err,
  output logic [2*N-1:0] phase_onehot,
  output logic [IW-1:0]  phase_idx,
  output logic           valid,
  output logic           illegal,
  output logic           seq_err,
  output logic           wrap_pulse,
  output logic [CW-1:0]  cycle_count,
  output logic           err_flag,
  output logic [EW-1:0]  err_count
);

  localparam logic [IW-1:0]  LAST    = IW'(2 * N - 1);
  localparam logic [2*N-1:0] OH_LAST = {1'b1, {(2*N-1){1'b0}}};
  localparam logic [EW-1:0]  ERR_MAX = '1;

  logic [N-1:0]   r_prev_code;
  logic           r_prev_ok;

  logic           w_in_legal;
  logic [IW-1:0]  w_in_idx;
  logic [2*N-1:0] w_in_oh;
  logic           w_prev_legal;
  logic [IW-1:0]  w_prev_idx;
  logic [2*N-1:0] w_prev_oh;
  logic [31:0]    w_next;
  logic           w_prev_last;
  logic           w_seq;
  logic           w_wrap;
  logic           w_err;

  johnson_decode #(.N(N), .IW(IW)) u_dec_in (
    .i_code   (count_in),
    .o_legal  (w_in_legal),
    .o_idx    (w_in_idx),
    .o_onehot (w_in_oh)
  );

  johnson_decode #(.N(N), .IW(IW)) u_dec_prev (
    .i_code   (r_prev_code),
    .o_legal  (w_prev_legal),
    .o_idx    (w_prev_idx),
    .o_onehot (w_prev_oh)
  );

  assign w_next = johnson_next(N, 32'(r_prev_code));

  assign w_prev_last = w_prev_legal
                     && (w_prev_idx == LAST)
                     && (w_prev_oh == OH_LAST);

  // A held code is fine; only a legal jump elsewhere is a sequence error.
  assign w_seq = r_prev_ok && w_in_legal
              && (count_in != r_prev_code)
              && (32'(count_in) != w_next);

  assign w_wrap = r_prev_ok && w_prev_last
               && w_in_legal && (w_in_idx == '0);

  assign w_err = ~w_in_legal | w_seq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_code  <= '0;
      r_prev_ok    <= 1'b0;
      phase_onehot <= '0;
      phase_idx    <= '0;
      valid        <= 1'b0;
      illegal      <= 1'b0;
      seq_err      <= 1'b0;
      wrap_pulse   <= 1'b0;
      cycle_count  <= '0;
      err_flag     <= 1'b0;
      err_count    <= '0;
    end else begin
      valid        <= 1'b1;
      phase_onehot <= w_in_oh;
      phase_idx    <= w_in_idx;
      illegal      <= ~w_in_legal;
      seq_err      <= w_seq;
      wrap_pulse   <= w_wrap;
      if (w_wrap) cycle_count <= cycle_count + 1'b1;

      // Illegal codes drop sync so the next legal code resyncs quietly.
      if (w_in_legal) begin
        r_prev_code <= count_in;
        r_prev_ok   <= 1'b1;
      end else begin
        r_prev_ok   <= 1'b0;
      end

      // A same-cycle error overrides clear_err.
      if (w_err) begin
        err_flag <= 1'b1;
        if (clear_err)               err_count <= EW'(1);
        else if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
      end else if (clear_err) begin
        err_flag  <= 1'b0;
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Scoreboard bench for johnson_phase_monitor: directed vectors push
// hand-computed expectations; a monitor pops one per clock and compares.
module tb_johnson_phase_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       clear_err;
  logic [7:0] phase_onehot;
  logic [2:0] phase_idx;
  logic       valid;
  logic       illegal;
  logic       seq_err;
  logic       wrap_pulse;
  logic [7:0] cycle_count;
  logic       err_flag;
  logic [3:0] err_count;

  johnson_phase_monitor #(.N(4), .IW(3), .CW(8), .EW(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .count_in     (count_in),
    .clear_err    (clear_err),
    .phase_onehot (phase_onehot),
    .phase_idx    (phase_idx),
    .valid        (valid),
    .illegal      (illegal),
    .seq_err      (seq_err),
    .wrap_pulse   (wrap_pulse),
    .cycle_count  (cycle_count),
    .err_flag     (err_flag),
    .err_count    (err_count)
  );

  typedef struct packed {
    logic       rst;
    logic [2:0] idx;
    logic       ill;
    logic       seq;
    logic       wrap;
    logic [7:0] cc;
    logic       flag;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, req, $time);
    end
  endtask

  // rst, clr, code -> expected idx, ill, seq, wrap, cc, flag, cnt
  task automatic v(input logic rst, input logic clr,
                   input logic [3:0] code, input int idx,
                   input int ill, input int seq, input int wrap,
                   input int cc, input int flag, input int cnt);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    clear_err = clr;
    count_in  = code;
    e.rst  = rst;
    e.idx  = 3'(idx);
    e.ill  = ill[0];
    e.seq  = seq[0];
    e.wrap = wrap[0];
    e.cc   = 8'(cc);
    e.flag = flag[0];
    e.cnt  = 4'(cnt);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic [7:0] eoh;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        eoh = (e.rst || e.ill) ? 8'h00 : (8'h01 << e.idx);
        chk("valid",        int'(valid),        int'(!e.rst));
        chk("phase_onehot", int'(phase_onehot), int'(eoh));
        chk("phase_idx",    int'(phase_idx),    int'(e.idx));
        chk("illegal",      int'(illegal),      int'(e.ill));
        chk("seq_err",      int'(seq_err),      int'(e.seq));
        chk("wrap_pulse",   int'(wrap_pulse),   int'(e.wrap));
        chk("cycle_count",  int'(cycle_count),  int'(e.cc));
        chk("err_flag",     int'(err_flag),     int'(e.flag));
        chk("err_count",    int'(err_count),    int'(e.cnt));
      end
    end
  end

  initial begin : driver
    reset     = 1'b1;
    clear_err = 1'b0;
    count_in  = 4'b0000;

    v(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    v(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);

    // full ring and wrap
    v(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0001, 1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0011, 2, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0111, 3, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b1111, 4, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b1110, 5, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b1100, 6, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b1000, 7, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0000, 0, 0, 0, 1, 1, 0, 0);

    // illegal code then resync on 1100
    v(0, 0, 4'b0001, 1, 0, 0, 0, 1, 0, 0);
    v(0, 0, 4'b0011, 2, 0, 0, 0, 1, 0, 0);
    v(0, 0, 4'b0101, 0, 1, 0, 0, 1, 1, 1);
    v(0, 0, 4'b1100, 6, 0, 0, 0, 1, 1, 1);
    v(0, 0, 4'b1000, 7, 0, 0, 0, 1, 1, 1);
    v(0, 0, 4'b0000, 0, 0, 0, 1, 2, 1, 1);

    // sequence jump 0011 -> 1110
    v(0, 0, 4'b0001, 1, 0, 0, 0, 2, 1, 1);
    v(0, 0, 4'b0011, 2, 0, 0, 0, 2, 1, 1);
    v(0, 0, 4'b1110, 5, 0, 1, 0, 2, 1, 2);
    v(0, 0, 4'b1100, 6, 0, 0, 0, 2, 1, 2);
    v(0, 0, 4'b1000, 7, 0, 0, 0, 2, 1, 2);
    v(0, 0, 4'b0000, 0, 0, 0, 1, 3, 1, 2);

    // hold 0111 for five cycles
    v(0, 0, 4'b0001, 1, 0, 0, 0, 3, 1, 2);
    v(0, 0, 4'b0011, 2, 0, 0, 0, 3, 1, 2);
    for (int i = 0; i < 5; i++)
      v(0, 0, 4'b0111, 3, 0, 0, 0, 3, 1, 2);

    // 20 illegal cycles: err_count 3..15 then holds at 15
    for (int i = 1; i <= 20; i++)
      v(0, 0, 4'b0101, 0, 1, 0, 0, 3, 1, (2 + i > 15) ? 15 : 2 + i);

    // clear alone, clear with error, clear alone again
    v(0, 1, 4'b0000, 0, 0, 0, 0, 3, 0, 0);
    v(0, 1, 4'b1010, 0, 1, 0, 0, 3, 1, 1);
    v(0, 1, 4'b0000, 0, 0, 0, 0, 3, 0, 0);

    // advance to phase 5, reset one cycle, resume at 0000
    v(0, 0, 4'b0001, 1, 0, 0, 0, 3, 0, 0);
    v(0, 0, 4'b0011, 2, 0, 0, 0, 3, 0, 0);
    v(0, 0, 4'b0111, 3, 0, 0, 0, 3, 0, 0);
    v(0, 0, 4'b1111, 4, 0, 0, 0, 3, 0, 0);
    v(0, 0, 4'b1110, 5, 0, 0, 0, 3, 0, 0);
    v(1, 0, 4'b1100, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0001, 1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0011, 2, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0111, 3, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b1111, 4, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b1110, 5, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b1100, 6, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b1000, 7, 0, 0, 0, 0, 0, 0);
    v(0, 0, 4'b0000, 0, 0, 0, 1, 1, 0, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++)
      @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
- Downstream consumer of the N-bit Johnson counter output (`count`).
- Registers each count value and decodes it to a one-hot phase of width 2N plus a binary phase index.
- Checks every code for legality and every transition for correct sequencing.
- Counts completed ring cycles and errors, giving the rest of the design clean phase strobes and a health status.

Parameters:
- N, 4: Johnson counter width; the ring has 2N legal states.
- IW, $clog2(2*N): width of the phase index.
- CW, 8: width of the completed-cycle counter (wraps).
- EW, 4: width of the error counter (saturates).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- count_in  in  N  code from the Johnson counter, sampled every clk.
- clear_err  in  1  synchronous clear of err_flag and err_count.
- phase_onehot  out  2N  one-hot decoded phase; all zeros when the code is illegal.
- phase_idx  out  IW  binary phase index 0..2N-1.
- valid  out  1  outputs reflect a sampled code.
- illegal  out  1  sampled code is not one of the 2N legal codes.
- seq_err  out  1  legal code that is neither the previous code nor its successor.
- wrap_pulse  out  1  one-cycle strobe on the phase 2N-1 -> 0 transition.
- cycle_count  out  CW  completed ring cycles, modulo 2^CW.
- err_flag  out  1  sticky; set by illegal or seq_err.
- err_count  out  EW  number of error cycles, saturating at 2^EW-1.

Behaviour:
- Ring definition:
  - next(c) = {c[N-2:0], ~c[N-1]}.
  - Phase k code: for k<=N, bits [k-1:0] set; for k>N, bits [N-1:k-N] set.
  - N=4 sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
- Reset (synchronous): all outputs 0; internal prev_code=0 and prev_ok=0.
- Latency: all outputs are registered and reflect the count_in sampled at the previous rising edge (1-cycle latency).
- Every non-reset cycle: valid=1.
- Legal code k: phase_onehot has only bit k set, phase_idx=k, illegal=0.
- Illegal code: phase_onehot=0, phase_idx=0, illegal=1, prev_ok<=0.
- seq_err=1 only when all of the following hold:
  - prev_ok=1;
  - count_in is legal;
  - count_in != prev_code;
  - count_in != next(prev_code).
- Holding the same code is legal, since the upstream counter may be stalled or held in reset.
- After any illegal code, or the first sample after reset, prev_ok=0, so the next legal code is accepted without seq_err (resync).
- Every legal code: prev_code<=count_in, prev_ok<=1. This includes codes that raised seq_err.
- wrap_pulse=1 when prev_ok=1, prev_code is phase 2N-1, and count_in is phase 0. On that cycle cycle_count increments, wrapping from 2^CW-1 to 0.
- Error cycle = illegal or seq_err is asserted.
- On an error cycle: err_flag<=1; err_count increments, holding at 2^EW-1.
- clear_err without an error: err_flag<=0, err_count<=0.
- clear_err with an error in the same cycle: the error wins; err_flag=1, err_count=1.
- Reset mid-operation: outputs return to 0 on the next edge; cycle_count and err_count are cleared; no seq_err is raised on the first post-reset code.

Decomposition:
- Package johnson_pkg:
  - function johnson_next(c);
  - function johnson_code(k) returning the phase-k code;
  - localparams for ring length 2N and IW.
- Sub-module johnson_decode (combinational): code in -> legal, idx, onehot out. It is instantiated twice, for count_in and prev_code.
- The monitor holds the registers, sequence check, and counters.

Test Plan:
- Reset held 2 cycles, then count_in stepped 0000->0001->0011->0111->1111->1110->1100->1000->0000:
  - phase_onehot walks 0x01..0x80, one cycle after each input;
  - phase_idx 0..7;
  - wrap_pulse=1 only on the 1000->0000 output cycle;
  - cycle_count=1;
  - err_flag=0.
- count_in=0101 for 1 cycle mid-sequence: illegal=1, phase_onehot=0, err_flag=1, err_count=1. The next legal code (e.g. 1100) gives no seq_err.
- count_in jumps 0011->1110: seq_err=1, phase_idx=5, err_count increments; the following 1100 gives seq_err=0.
- count_in held at 0111 for 5 cycles: phase_idx=3 throughout, seq_err=0; cycle_count and err_count unchanged.
- 20 consecutive illegal cycles with EW=4: err_count saturates at 15. Then clear_err alone gives err_flag=0, err_count=0. clear_err together with an illegal code gives err_flag=1, err_count=1.
- reset asserted mid-ring at phase 5 for 1 cycle, then count_in resumes at 0000: all outputs 0 during reset; no seq_err on resume; cycle_count restarts from 0.
